// File: rtl/spi_master_gen_pkg.sv
// Shared constants for the SPI master: FSM state encodings, default sizes
// and SPI mode encodings ({cpol, cpha}) with small decode helpers.
package spi_master_gen_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DIV_W_DEF  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        XFER  = ST_XFER,
        HOLD  = ST_HOLD
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic mode_cpol(input logic [1:0] m);
        return (m == MODE2) || (m == MODE3);
    endfunction

    function automatic logic mode_cpha(input logic [1:0] m);
        return (m == MODE1) || (m == MODE3);
    endfunction

endpackage

// File: rtl/spi_clk_prescaler.sv
// SCLK prescaler: produces a registered one-cycle tick every div+1 clk cycles.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart the count; the first tick then lands div+1 cycles later
//   div         terminal count (half-SCLK period minus one)
//   tick        registered enable
module spi_clk_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    assign cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;

    // The tick is registered one cycle ahead of the count reaching its
    // terminal value so that the consumer acts exactly div+1 edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (clear) begin
            cnt_q  <= '0;
            tick_q <= (div == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == div);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/spi_master_gen.sv
// SPI master: one full-duplex DATA_W-bit word per accepted start, MSB first,
// run-time CPOL/CPHA and programmable SCLK rate.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             request, accepted only while busy=0
//   clk_scaler        half-SCLK period = clk_scaler+1 clk cycles
//   cpol, cpha        SPI mode, captured with tx_data on the accepted start
//   tx_data/rx_data   word to send / last word received
//   busy, done        transfer in progress / one-cycle end pulse
//   sclk, cs_n, mosi  registered serial pins; miso serial input
module spi_master_gen
    import spi_master_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIV_W-1:0]  clk_scaler,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int               CNT_W    = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_TOG = CNT_W'(2 * DATA_W);

    state_t            state_q;
    logic [DATA_W-1:0] shift_q, rx_q;
    logic [CNT_W-1:0]  tog_q, tog_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q;
    logic              sclk_q, cs_n_q, mosi_q, busy_q, done_q;
    logic              accept, tick, cpha_c;

    assign accept = start && !busy_q;
    // The prescaler is cleared by the accepting edge, so it must see the
    // new scaler value in that same cycle.
    assign div_d  = accept ? clk_scaler : div_q;
    assign tog_d  = tog_q + 1'b1;
    assign cpha_c = mode_cpha(mode_q);

    spi_clk_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(accept),
        .div  (div_d),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            tog_q   <= '0;
            div_q   <= '0;
            mode_q  <= MODE0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    cs_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= cpha ? 1'b0 : tx_data[DATA_W-1];
                        shift_q <= tx_data;
                        mode_q  <= {cpol, cpha};
                        div_q   <= clk_scaler;
                        tog_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                // SETUP's tick is toggle 1 (a leading edge), so it shares the
                // edge handling with XFER. Odd toggle counts are leading edges.
                SETUP, XFER: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        tog_q  <= tog_d;
                        if (tog_d[0]) begin
                            if (cpha_c) mosi_q  <= shift_q[DATA_W-1];
                            else        shift_q <= {shift_q[DATA_W-2:0], miso};
                        end else begin
                            if (cpha_c)                  shift_q <= {shift_q[DATA_W-2:0], miso};
                            else if (tog_d != LAST_TOG) mosi_q  <= shift_q[DATA_W-1];
                        end
                        state_q <= (tog_d == LAST_TOG) ? HOLD : XFER;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        rx_q    <= shift_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
module tb_spi_master_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared mode/rate inputs; each DUT captures them only on its own start.
    logic       cpol = 1'b0, cpha = 1'b0;
    logic [7:0] scaler = 8'd0;

    // 8-bit instance
    logic       start = 1'b0, loop = 1'b0, miso_m = 1'b0;
    logic [7:0] tx = 8'h00, rx;
    logic       busy, done, sclk, cs_n, mosi, miso;
    assign miso = loop ? mosi : miso_m;

    spi_master_gen #(.DATA_W(8), .DIV_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .clk_scaler(scaler),
        .cpol(cpol), .cpha(cpha), .tx_data(tx), .rx_data(rx),
        .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    // 16-bit instance
    logic        start16 = 1'b0, miso16 = 1'b0;
    logic [15:0] tx16 = 16'h0000, rx16;
    logic        busy16, done16, sclk16, cs16, mosi16;

    spi_master_gen #(.DATA_W(16), .DIV_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .clk_scaler(scaler),
        .cpol(cpol), .cpha(cpha), .tx_data(tx16), .rx_data(rx16),
        .busy(busy16), .done(done16), .sclk(sclk16), .cs_n(cs16),
        .mosi(mosi16), .miso(miso16)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected transfer parameters and slave word, set by the tests.
    logic       exp_cpol = 1'b0, exp_cpha = 1'b0;
    logic [7:0] sword = 8'h00;
    int         start_cyc = 0;

    // Monitor + slave model for the 8-bit instance.
    int         tog_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
    int         last_tog = 0, hmin = 0, hmax = 0, hlen, sidx = 7;
    logic [7:0] mosi_cap = 8'h00;
    logic       sclk_prev = 1'b0, cs_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (cs_prev && !cs_n) begin
            tog_cnt = 0; busy_cnt = 0; last_tog = cyc;
            hmin = 1 << 30; hmax = 0; mosi_cap = 8'h00; sidx = 7;
            if (!exp_cpha) miso_m = sword[7];
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (sclk !== sclk_prev && !cs_n) begin
            tog_cnt++;
            hlen = cyc - last_tog;
            if (hlen < hmin) hmin = hlen;
            if (hlen > hmax) hmax = hlen;
            last_tog = cyc;
            if (sclk !== exp_cpol) begin
                mosi_cap = {mosi_cap[6:0], mosi};
                if (exp_cpha && sidx >= 0) begin miso_m = sword[sidx]; sidx--; end
            end else if (!exp_cpha && tog_cnt < 16 && sidx > 0) begin
                sidx--; miso_m = sword[sidx];
            end
        end
        sclk_prev = sclk;
        cs_prev   = cs_n;
    end

    // Monitor for the 16-bit instance.
    int          tog16 = 0, done16_cnt = 0, done16_cyc = 0;
    logic [15:0] cap16 = 16'h0000;
    logic        sclk16_prev = 1'b0, cs16_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (cs16_prev && !cs16) begin tog16 = 0; cap16 = 16'h0000; end
        if (done16) begin done16_cnt++; done16_cyc = cyc; end
        if (sclk16 !== sclk16_prev && !cs16) begin
            tog16++;
            if (sclk16 !== 1'b0) cap16 = {cap16[14:0], mosi16};
        end
        sclk16_prev = sclk16;
        cs16_prev   = cs16;
    end

    task automatic do_start(input logic [7:0] d);
        @(negedge clk);
        tx = d; start = 1'b1; start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
        ok = (done_cnt >= target);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic [7:0] sc,
                            input logic lp, input logic [7:0] sw);
        @(negedge clk);
        cpol = pol; cpha = pha; scaler = sc; loop = lp; sword = sw;
        exp_cpol = pol; exp_cpha = pha;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_pins: got cs_n,sclk,mosi,busy,done=%b want 10000", {cs_n, sclk, mosi, busy, done});
        end
        n_cmp++;
        if (rx !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_loopback;
        bit ok;
        int base = done_cnt;
        set_mode(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
        n_cmp++;
        if (sclk !== 1'b0) begin n_bad++; $display("FAIL m0_idle_sclk: got %b want 0", sclk); end
        do_start(8'hA5);
        wait_done(base + 1, 100, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL m0_done_timeout: got no done want done"); end
        n_cmp++;
        if (mosi_cap !== 8'hA5) begin n_bad++; $display("FAIL m0_mosi_bits: got %h want a5", mosi_cap); end
        n_cmp++;
        if (rx !== 8'hA5) begin n_bad++; $display("FAIL m0_rx: got %h want a5", rx); end
        n_cmp++;
        if (done_cyc - start_cyc !== 17) begin n_bad++; $display("FAIL m0_latency: got %0d want 17", done_cyc - start_cyc); end
        n_cmp++;
        if (tog_cnt !== 16) begin n_bad++; $display("FAIL m0_toggles: got %0d want 16", tog_cnt); end
        n_cmp++;
        if ({cs_n, sclk} !== 2'b10) begin n_bad++; $display("FAIL m0_end_pins: got cs_n,sclk=%b want 10", {cs_n, sclk}); end
    endtask

    task automatic test_mode3;
        bit ok;
        int base = done_cnt;
        set_mode(1'b1, 1'b1, 8'd3, 1'b0, 8'hC3);
        n_cmp++;
        if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_idle_sclk: got %b want 1", sclk); end
        do_start(8'h3C);
        wait_done(base + 1, 200, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL m3_done_timeout: got no done want done"); end
        n_cmp++;
        if (rx !== 8'hC3) begin n_bad++; $display("FAIL m3_rx: got %h want c3", rx); end
        n_cmp++;
        if (mosi_cap !== 8'h3C) begin n_bad++; $display("FAIL m3_mosi_bits: got %h want 3c", mosi_cap); end
        n_cmp++;
        if (busy_cnt !== 68) begin n_bad++; $display("FAIL m3_busy_span: got %0d want 68", busy_cnt); end
        n_cmp++;
        if (hmin !== 4 || hmax !== 4) begin n_bad++; $display("FAIL m3_half_period: got min %0d max %0d want 4 4", hmin, hmax); end
        n_cmp++;
        if (done_cyc - start_cyc !== 68) begin n_bad++; $display("FAIL m3_latency: got %0d want 68", done_cyc - start_cyc); end
        n_cmp++;
        if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_end_sclk: got %b want 1", sclk); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        int base = done_cnt;
        int s;
        set_mode(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
        do_start(8'h96);
        s = start_cyc;
        while (cyc < s + 4) @(negedge clk);
        start = 1'b1;                       // seen at edge s+5, mid-transfer
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 16) @(negedge clk);
        start = 1'b1;                       // seen at the done-producing edge
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_cnt !== base + 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want %0d", done_cnt, base + 1); end
        n_cmp++;
        if ({busy, cs_n} !== 2'b01) begin n_bad++; $display("FAIL ign_idle: got busy,cs_n=%b want 01", {busy, cs_n}); end
        n_cmp++;
        if (rx !== 8'h96) begin n_bad++; $display("FAIL ign_rx: got %h want 96", rx); end
        // Back-to-back: start raised in the cycle right after done.
        do_start(8'h3C);
        wait_done(base + 2, 100, ok);
        start = 1'b1; tx = 8'hE1; start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, cs_n} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept: got busy,cs_n=%b want 10", {busy, cs_n}); end
        wait_done(base + 3, 100, ok);
        n_cmp++;
        if (!ok || rx !== 8'hE1) begin n_bad++; $display("FAIL b2b_rx: got %h want e1", rx); end
        n_cmp++;
        if (done_cyc - start_cyc !== 17) begin n_bad++; $display("FAIL b2b_latency: got %0d want 17", done_cyc - start_cyc); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int base;
        int n = 0;
        set_mode(1'b1, 1'b0, 8'd1, 1'b1, 8'h00);
        do_start(8'h5A);
        while (tog_cnt < 6 && n < 100) begin @(negedge clk); n++; end
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs_n, busy, sclk} !== 3'b100) begin n_bad++; $display("FAIL rstmid_pins: got cs_n,busy,sclk=%b want 100", {cs_n, busy, sclk}); end
        n_cmp++;
        if (rx !== 8'h00) begin n_bad++; $display("FAIL rstmid_rx: got %h want 00", rx); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (done_cnt !== base) begin n_bad++; $display("FAIL rstmid_no_done: got %0d dones want %0d", done_cnt, base); end
        do_start(8'hC6);
        wait_done(base + 1, 100, ok);
        n_cmp++;
        if (!ok || rx !== 8'hC6) begin n_bad++; $display("FAIL rstmid_rx_after: got %h want c6", rx); end
        n_cmp++;
        if (mosi_cap !== 8'hC6) begin n_bad++; $display("FAIL rstmid_mosi_after: got %h want c6", mosi_cap); end
        n_cmp++;
        if (done_cyc - start_cyc !== 34) begin n_bad++; $display("FAIL rstmid_latency: got %0d want 34", done_cyc - start_cyc); end
    endtask

    task automatic test_capture;
        bit ok;
        int base = done_cnt;
        set_mode(1'b0, 1'b1, 8'd2, 1'b0, 8'h96);
        do_start(8'h5A);
        tx = 8'hFF; cpol = 1'b1; cpha = 1'b0; scaler = 8'd0;
        wait_done(base + 1, 200, ok);
        n_cmp++;
        if (!ok || rx !== 8'h96) begin n_bad++; $display("FAIL cap_rx: got %h want 96", rx); end
        n_cmp++;
        if (mosi_cap !== 8'h5A) begin n_bad++; $display("FAIL cap_mosi: got %h want 5a", mosi_cap); end
        n_cmp++;
        if (done_cyc - start_cyc !== 51) begin n_bad++; $display("FAIL cap_latency: got %0d want 51", done_cyc - start_cyc); end
        n_cmp++;
        if (hmin !== 3 || hmax !== 3 || tog_cnt !== 16) begin
            n_bad++; $display("FAIL cap_waveform: got half %0d..%0d toggles %0d want 3..3 16", hmin, hmax, tog_cnt);
        end
        set_mode(1'b0, 1'b0, 8'd0, 1'b0, 8'h00);
    endtask

    task automatic test_long;
        int n = 0;
        int s;
        set_mode(1'b0, 1'b0, 8'd255, 1'b0, 8'h00);
        @(negedge clk);
        tx16 = 16'hFFFF; start16 = 1'b1; s = cyc + 1;
        @(negedge clk);
        start16 = 1'b0;
        while (done16_cnt < 1 && n < 9000) begin @(negedge clk); n++; end
        n_cmp++;
        if (done16_cnt !== 1) begin n_bad++; $display("FAIL long_done: got %0d dones want 1", done16_cnt); end
        n_cmp++;
        if (done16_cyc - s !== 8448) begin n_bad++; $display("FAIL long_latency: got %0d want 8448", done16_cyc - s); end
        n_cmp++;
        if (rx16 !== 16'h0000) begin n_bad++; $display("FAIL long_rx: got %h want 0000", rx16); end
        n_cmp++;
        if (tog16 !== 32) begin n_bad++; $display("FAIL long_toggles: got %0d want 32", tog16); end
        n_cmp++;
        if (cap16 !== 16'hFFFF) begin n_bad++; $display("FAIL long_mosi: got %h want ffff", cap16); end
    endtask

    initial begin
        test_reset;
        test_mode0_loopback;
        test_mode3;
        test_start_ignored;
        test_reset_mid;
        test_capture;
        test_long;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised SPI master for serial ADC/DAC-style peripherals: one full-duplex word per `start`, MSB first.
- Programmable SCLK prescaler, run-time CPOL/CPHA mode, MISO capture into `rx_data`.
- start/busy/done handshake.
- Sits between the control FSMs and the external chip-select/clock/data pins; replaces fixed-size, mode-0-only transfer logic.

Parameters:
- DATA_W, 16, bits per transfer (legal 2..32).
- DIV_W, 8, width of `clk_scaler`.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; honoured only when busy=0.
- clk_scaler  in  DIV_W  half-SCLK period = clk_scaler+1 clk cycles.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- tx_data  in  DATA_W  word to send.
- rx_data  out  DATA_W  last received word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- sclk  out  1  serial clock.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-transfer:
  - cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - State IDLE, prescaler and bit counters 0.
  - Transfer is abandoned; no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- Tick: one-cycle enable from the prescaler every clk_scaler+1 clk cycles.
  - The prescaler is cleared on an accepted start, so the first tick falls exactly clk_scaler+1 cycles later.
  - clk_scaler=0 gives a tick every cycle.
- Sampling at start: tx_data, cpol, cpha and clk_scaler are captured on the accepted start edge. Later changes have no effect until the next transfer.
- start while busy=1 is ignored (not queued).
- IDLE:
  - sclk follows cpol each cycle; cs_n=1; mosi=0.
  - On start: busy=1, cs_n=0, mosi=tx_data[DATA_W-1] if cpha=0 (else 0), go to SETUP.
- SETUP (one half-period): on tick, toggle sclk (leading edge 1), go to XFER.
- XFER:
  - Each tick toggles sclk. Toggles are counted 1..2*DATA_W, odd = leading, even = trailing.
  - cpha=0: sample miso into the shift register on leading edges; shift next bit onto mosi on trailing edges 1..DATA_W-1.
  - cpha=1: shift bit onto mosi on leading edges; sample miso on trailing edges.
  - After toggle 2*DATA_W, sclk=cpol; go to HOLD.
- HOLD (one half-period): on tick:
  - cs_n=1, mosi=0, busy=0.
  - rx_data is loaded with the shift register.
  - done=1 for exactly one cycle; back to IDLE.
- Latency: done rises (2*DATA_W+1)*(clk_scaler+1) cycles after the start edge; busy is high for the same span.
- Back-to-back: start is accepted in the cycle after done, giving a minimum cs_n high time of 1 clk.
- start coinciding with done is ignored because busy is still 1 in that cycle.
- Bit order: MSB first on both mosi and rx_data. rx_data[DATA_W-1] is the first bit sampled.
- Counters:
  - Bit counter width is clog2(2*DATA_W+1).
  - Prescaler compare is `==`; counting wraps to 0 on tick, no overflow.

Decomposition:
- Shared constants header holds:
  - State encodings IDLE/SETUP/XFER/HOLD (2-bit localparams).
  - Default DATA_W/DIV_W.
  - Mode encodings MODE0..MODE3 as {cpol,cpha}.
- One sub-module, spi_clk_prescaler.
  - Inputs: clk, rst_n, clear, div.
  - Output: tick. Registered enable; counter reset to 0 by clear or rst_n.
- FSM, shift register and pin registers stay in spi_master_gen.

Test Plan:
1. DATA_W=8, clk_scaler=0, mode 0, tx_data=0xA5, miso looped to mosi → 8 leading edges see mosi=1,0,1,0,0,1,0,1; rx_data=0xA5; done 17 cycles after start; sclk idles 0.
2. Mode 3 (cpol=1, cpha=1), clk_scaler=3, tx_data=0x3C, miso driven by model returning 0xC3 → sclk idles 1; each half-period is 4 cycles; rx_data=0xC3; busy high for 68 cycles.
3. start pulsed again at cycle 5 of a transfer, plus start coincident with done → both ignored; exactly one done per accepted start; second transfer starts only when start is raised after done.
4. rst_n asserted mid-XFER (after bit 3) → same cycle: cs_n=1, busy=0, sclk=0; no done pulse; next start produces a full, correct transfer.
5. tx_data/cpol/clk_scaler changed while busy → current transfer uses the captured values; the waveform is unchanged vs. the golden model.
6. DATA_W=16, clk_scaler=255, tx_data=0xFFFF, miso=0 → 32 sclk toggles, rx_data=0x0000, done at (33*256) cycles.
